// File: rtl/diff_ctrl_pkg.sv
// Shared types for the difftest run controller: FSM states, host command
// opcodes and halt cause codes.
package diff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_STOP  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_STOP      = 3'd1,
        CAUSE_STEP_DONE = 3'd2,
        CAUSE_TRAP      = 3'd3,
        CAUSE_TIMEOUT   = 3'd4
    } halt_cause_e;

    // RUN and PAUSE are the states in which the DUT is considered active.
    function automatic logic is_active(state_e s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/diff_step_ctrl_if.sv
// Host command bus plus DUT commit/back-pressure signals seen by the run
// controller. The controller is the slave; host and DUT side is the master.
interface diff_step_ctrl_if #(
    parameter int STEP_W = 32
);
    import diff_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    cmd_op_e           cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic              commit_valid;
    logic              commit_trap;
    logic              buf_full;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, commit_valid, commit_trap, buf_full,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, commit_valid, commit_trap, buf_full,
        output cmd_ready
    );

endinterface

// File: rtl/diff_watchdog.sv
// No-commit watchdog: counts enabled cycles without a commit and flags
// expiry once TIMEOUT such cycles have accumulated. The count saturates
// at TIMEOUT so the flag stays up until cleared.
module diff_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic tick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise advance on enabled cycles up to LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/diff_step_ctrl.sv
// Run controller for the difftest DUT clock domain. Generates the DUT clock
// enable, executes host RUN/STEP/STOP/CLEAR commands, counts commits and
// enabled cycles, halts on trap, exhausted step budget or STOP, and pauses
// while the commit buffer is full.
// Optional build macro DIFF_TIMEOUT_EN adds a no-commit watchdog that halts
// with cause TIMEOUT after TIMEOUT enabled cycles without a commit.
module diff_step_ctrl
    import diff_ctrl_pkg::*;
#(
    parameter int          CNT_W   = 64,
    parameter int          STEP_W  = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clock,
    input  logic               reset,
    diff_step_ctrl_if.slave    bus,
    output logic               dut_clk_en,
    output logic               busy,
    output logic               halted,
    output logic [2:0]         halt_cause,
    output logic               halt_pulse,
    output logic               cmd_err,
    output logic [CNT_W-1:0]   commit_cnt,
    output logic [CNT_W-1:0]   cycle_cnt
);

    state_e            state_q,      state_d;
    logic [STEP_W-1:0] remain_q,     remain_d;
    logic              budget_en_q,  budget_en_d;
    halt_cause_e       cause_q,      cause_d;
    logic              pulse_q,      pulse_d;
    logic              err_q,        err_d;
    logic              busy_q,       busy_d;
    logic              halted_q,     halted_d;
    logic [CNT_W-1:0]  commit_cnt_q, commit_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q,  cycle_cnt_d;

    logic stop_cmd;
    logic trap_hit;
    logic last_hit;
    logic wd_hit;
    logic halt_now;
    logic wd_expired;

    assign bus.cmd_ready = 1'b1;

`ifdef DIFF_TIMEOUT_EN
    // The watchdog only runs in RUN: leaving RUN (PAUSE, HALT, IDLE) clears
    // it, which also guarantees a fresh count on every entry to RUN.
    diff_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clr     (bus.commit_valid || (state_q != ST_RUN)),
        .tick    (dut_clk_en),
        .expired (wd_expired)
    );
`else
    // No watchdog in this build; the timeout limit is never reached.
    localparam bit WD_PRESENT = 1'b0;
    assign wd_expired = WD_PRESENT && (TIMEOUT != 0);
`endif

    // Same-cycle halt conditions; these also gate the clock enable so the
    // halting commit is the last one the DUT produces.
    always_comb begin
        stop_cmd = bus.cmd_valid && (bus.cmd_op == OP_STOP);
        trap_hit = bus.commit_valid && bus.commit_trap;
        last_hit = bus.commit_valid && budget_en_q && (remain_q == STEP_W'(1));
        wd_hit   = (state_q == ST_RUN) && wd_expired;
        halt_now = is_active(state_q) && (trap_hit || last_hit || stop_cmd || wd_hit);
    end

    assign dut_clk_en = (state_q == ST_RUN) && !bus.buf_full && !halt_now;

    // Next-state, counter and status computation.
    always_comb begin
        state_d      = state_q;
        remain_d     = remain_q;
        budget_en_d  = budget_en_q;
        cause_d      = cause_q;
        pulse_d      = 1'b0;
        err_d        = err_q;
        commit_cnt_d = commit_cnt_q;
        cycle_cnt_d  = cycle_cnt_q + CNT_W'(dut_clk_en);

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_RUN: begin
                            state_d     = ST_RUN;
                            budget_en_d = 1'b0;
                        end
                        OP_STEP: begin
                            if (bus.cmd_arg == '0) begin
                                state_d = ST_HALT;
                                cause_d = CAUSE_STEP_DONE;
                                pulse_d = 1'b1;
                            end else begin
                                state_d     = ST_RUN;
                                remain_d    = bus.cmd_arg;
                                budget_en_d = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            state_d      = ST_IDLE;
                            cause_d      = CAUSE_NONE;
                            err_d        = 1'b0;
                            commit_cnt_d = '0;
                            cycle_cnt_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end

            default: begin
                // RUN or PAUSE; late commits in PAUSE are handled the same way.
                if (bus.commit_valid) begin
                    commit_cnt_d = commit_cnt_q + CNT_W'(1);
                    if (budget_en_q) begin
                        remain_d = remain_q - STEP_W'(1);
                    end
                end
                if (bus.cmd_valid && (bus.cmd_op != OP_STOP)) begin
                    err_d = 1'b1;
                end
                if (halt_now) begin
                    state_d = ST_HALT;
                    pulse_d = 1'b1;
                    if (trap_hit) begin
                        cause_d = CAUSE_TRAP;
                    end else if (last_hit) begin
                        cause_d = CAUSE_STEP_DONE;
                    end else if (stop_cmd) begin
                        cause_d = CAUSE_STOP;
                    end else begin
                        cause_d = CAUSE_TIMEOUT;
                    end
                end else if ((state_q == ST_RUN) && bus.buf_full) begin
                    state_d = ST_PAUSE;
                end else if ((state_q == ST_PAUSE) && !bus.buf_full) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        busy_d   = is_active(state_d);
        halted_d = (state_d == ST_HALT);
    end

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            remain_q     <= '0;
            budget_en_q  <= 1'b0;
            cause_q      <= CAUSE_NONE;
            pulse_q      <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            halted_q     <= 1'b0;
            commit_cnt_q <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            budget_en_q  <= budget_en_d;
            cause_q      <= cause_d;
            pulse_q      <= pulse_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            halted_q     <= halted_d;
            commit_cnt_q <= commit_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    assign busy       = busy_q;
    assign halted     = halted_q;
    assign halt_cause = cause_q;
    assign halt_pulse = pulse_q;
    assign cmd_err    = err_q;
    assign commit_cnt = commit_cnt_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_diff_step_ctrl.sv
// Bench for diff_step_ctrl: directed vector table, reset-mid-run sequence,
// optional watchdog sequences (DIFF_TIMEOUT_EN) and a randomized run checked
// against a behavioural model.
module tb_diff_step_ctrl;
    import diff_ctrl_pkg::*;

    localparam int          CNT_W      = 64;
    localparam int          STEP_W     = 32;
    localparam int unsigned TB_TIMEOUT = 16;

    logic              clock;
    logic              reset;
    logic              dut_clk_en;
    logic              busy;
    logic              halted;
    logic [2:0]        halt_cause;
    logic              halt_pulse;
    logic              cmd_err;
    logic [CNT_W-1:0]  commit_cnt;
    logic [CNT_W-1:0]  cycle_cnt;

    diff_step_ctrl_if #(.STEP_W(STEP_W)) bus ();

    diff_step_ctrl #(
        .CNT_W   (CNT_W),
        .STEP_W  (STEP_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .dut_clk_en (dut_clk_en),
        .busy       (busy),
        .halted     (halted),
        .halt_cause (halt_cause),
        .halt_pulse (halt_pulse),
        .cmd_err    (cmd_err),
        .commit_cnt (commit_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit              cv;
        cmd_op_e         op;
        int unsigned     arg;
        bit              cm;
        bit              tr;
        bit              fl;
        bit              en;
        bit              bs;
        bit              hl;
        int              cause;
        bit              pl;
        bit              er;
        longint unsigned com;
        longint unsigned cyc;
    } vec_t;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 running, 2 paused, 3 halted
    int              m_mode;
    int unsigned     m_left;
    bit              m_lim;
    int              m_cause;
    bit              m_pulse;
    bit              m_err;
    longint unsigned m_com;
    longint unsigned m_cyc;
    int unsigned     m_idle_run;

    task automatic m_reset();
        m_mode = 0; m_left = 0; m_lim = 0; m_cause = 0; m_pulse = 0;
        m_err = 0; m_com = 0; m_cyc = 0; m_idle_run = 0;
    endtask

    function automatic bit m_wd_out();
`ifdef DIFF_TIMEOUT_EN
        return (m_mode == 1) && (m_idle_run >= TB_TIMEOUT);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int m_halt_reason(vec_t v);
        if (!(m_mode == 1 || m_mode == 2)) return 0;
        if (v.cm && v.tr) return 3;
        if (v.cm && m_lim && m_left == 1) return 2;
        if (v.cv && v.op == OP_STOP) return 1;
        if (m_wd_out()) return 4;
        return 0;
    endfunction

    function automatic bit m_en(vec_t v);
        return (m_mode == 1) && !v.fl && (m_halt_reason(v) == 0);
    endfunction

    task automatic m_step(vec_t v);
        bit en;
        int why;
        en  = m_en(v);
        why = m_halt_reason(v);
        m_pulse = 0;
        if (en) m_cyc++;
        if (m_mode != 1 || v.cm) m_idle_run = 0;
        else if (en) m_idle_run++;
        if (m_mode == 0 || m_mode == 3) begin
            if (v.cv) begin
                if (v.op == OP_RUN) begin
                    m_mode = 1; m_lim = 0;
                end else if (v.op == OP_STEP) begin
                    if (v.arg == 0) begin
                        m_mode = 3; m_cause = 2; m_pulse = 1;
                    end else begin
                        m_mode = 1; m_left = v.arg; m_lim = 1;
                    end
                end else if (v.op == OP_CLEAR) begin
                    m_mode = 0; m_cause = 0; m_err = 0; m_com = 0; m_cyc = 0;
                end
            end
        end else begin
            if (v.cm) begin
                m_com++;
                if (m_lim) m_left--;
            end
            if (v.cv && v.op != OP_STOP) m_err = 1;
            if (why != 0) begin
                m_mode = 3; m_cause = why; m_pulse = 1;
            end else if (m_mode == 1 && v.fl) begin
                m_mode = 2;
            end else if (m_mode == 2 && !v.fl) begin
                m_mode = 1;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(bit cv, cmd_op_e op, int unsigned arg, bit cm, bit tr, bit fl,
                                bit en, bit bs, bit hl, int cause, bit pl, bit er,
                                longint unsigned com, longint unsigned cyc);
        vec_t v;
        v.cv = cv; v.op = op; v.arg = arg; v.cm = cm; v.tr = tr; v.fl = fl;
        v.en = en; v.bs = bs; v.hl = hl; v.cause = cause; v.pl = pl; v.er = er;
        v.com = com; v.cyc = cyc;
        return v;
    endfunction

    function automatic vec_t idle_vec();
        return mk(0, OP_CLEAR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // One clock cycle: called just after a falling edge. Drives inputs,
    // checks the combinational enable, clocks, then checks registered outputs.
    task automatic run_cycle(input vec_t v, input bit use_model, input string tag, output bit en_seen);
        bit exp_en;
        bus.cmd_valid    = v.cv;
        bus.cmd_op       = v.op;
        bus.cmd_arg      = v.arg;
        bus.commit_valid = v.cm;
        bus.commit_trap  = v.tr;
        bus.buf_full     = v.fl;
        #1;
        exp_en  = use_model ? m_en(v) : v.en;
        en_seen = dut_clk_en;
        chk({tag, ".dut_clk_en"}, dut_clk_en, exp_en);
        @(posedge clock);
        m_step(v);
        @(negedge clock);
        if (use_model) begin
            chk({tag, ".busy"},       busy,       (m_mode == 1 || m_mode == 2));
            chk({tag, ".halted"},     halted,     (m_mode == 3));
            chk({tag, ".halt_cause"}, halt_cause, m_cause);
            chk({tag, ".halt_pulse"}, halt_pulse, m_pulse);
            chk({tag, ".cmd_err"},    cmd_err,    m_err);
            chk({tag, ".commit_cnt"}, commit_cnt, m_com);
            chk({tag, ".cycle_cnt"},  cycle_cnt,  m_cyc);
        end else begin
            chk({tag, ".busy"},       busy,       v.bs);
            chk({tag, ".halted"},     halted,     v.hl);
            chk({tag, ".halt_cause"}, halt_cause, v.cause);
            chk({tag, ".halt_pulse"}, halt_pulse, v.pl);
            chk({tag, ".cmd_err"},    cmd_err,    v.er);
            chk({tag, ".commit_cnt"}, commit_cnt, v.com);
            chk({tag, ".cycle_cnt"},  cycle_cnt,  v.cyc);
        end
    endtask

    task automatic apply_reset(input string tag);
        vec_t v;
        v = idle_vec();
        bus.cmd_valid = 0; bus.cmd_op = OP_CLEAR; bus.cmd_arg = 0;
        bus.commit_valid = 0; bus.commit_trap = 0; bus.buf_full = 0;
        reset = 1'b1;
        @(posedge clock);
        m_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk({tag, ".dut_clk_en"}, dut_clk_en, m_en(v));
        chk({tag, ".cmd_ready"},  bus.cmd_ready, 1);
        chk({tag, ".busy"},       busy, 0);
        chk({tag, ".halted"},     halted, 0);
        chk({tag, ".halt_cause"}, halt_cause, 0);
        chk({tag, ".halt_pulse"}, halt_pulse, 0);
        chk({tag, ".cmd_err"},    cmd_err, 0);
        chk({tag, ".commit_cnt"}, commit_cnt, 0);
        chk({tag, ".cycle_cnt"},  cycle_cnt, 0);
        @(negedge clock);
    endtask

    vec_t tbl[$];

    initial begin
        bit   en_seen;
        vec_t v;
        int   en_count;

        reset = 1'b1;
        bus.cmd_valid = 0; bus.cmd_op = OP_CLEAR; bus.cmd_arg = 0;
        bus.commit_valid = 0; bus.commit_trap = 0; bus.buf_full = 0;
        m_reset();
        @(negedge clock);
        apply_reset("reset");

        //              cv op        arg cm tr fl  en  bs hl cs pl er  com cyc
        // STEP 5, commits trail each enabled cycle by one
        tbl.push_back(mk(1, OP_STEP,  5, 0, 0, 0,  0,  1, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 0,  1,  1, 0, 0, 0, 0,  0, 1));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 0, 0,  1,  1, 0, 0, 0, 0,  1, 2));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 0, 0,  1,  1, 0, 0, 0, 0,  2, 3));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 0, 0,  1,  1, 0, 0, 0, 0,  3, 4));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 0, 0,  1,  1, 0, 0, 0, 0,  4, 5));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 0, 0,  0,  0, 1, 2, 1, 0,  5, 5));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 0,  0,  0, 1, 2, 0, 0,  5, 5));
        // RUN with 3 cycles of buf_full, then STOP while paused
        tbl.push_back(mk(1, OP_RUN,   0, 0, 0, 0,  0,  1, 0, 2, 0, 0,  5, 5));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 0,  1,  1, 0, 2, 0, 0,  5, 6));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 1,  0,  1, 0, 2, 0, 0,  5, 6));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 1,  0,  1, 0, 2, 0, 0,  5, 6));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 1,  0,  1, 0, 2, 0, 0,  5, 6));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 0,  0,  1, 0, 2, 0, 0,  5, 6));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 0,  1,  1, 0, 2, 0, 0,  5, 7));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 1,  0,  1, 0, 2, 0, 0,  5, 7));
        tbl.push_back(mk(1, OP_STOP,  0, 0, 0, 1,  0,  0, 1, 1, 1, 0,  5, 7));
        // illegal CLEAR / STEP while running, then CLEAR in HALT, STEP 0
        tbl.push_back(mk(1, OP_RUN,   0, 0, 0, 0,  0,  1, 0, 1, 0, 0,  5, 7));
        tbl.push_back(mk(1, OP_CLEAR, 0, 0, 0, 0,  1,  1, 0, 1, 0, 1,  5, 8));
        tbl.push_back(mk(1, OP_STEP,  3, 1, 0, 0,  1,  1, 0, 1, 0, 1,  6, 9));
        tbl.push_back(mk(1, OP_STOP,  0, 0, 0, 0,  0,  0, 1, 1, 1, 1,  6, 9));
        tbl.push_back(mk(1, OP_CLEAR, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(1, OP_STEP,  0, 0, 0, 0,  0,  0, 1, 2, 1, 0,  0, 0));
        // STEP 10 with trap on the third commit
        tbl.push_back(mk(1, OP_STEP, 10, 0, 0, 0,  0,  1, 0, 2, 0, 0,  0, 0));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 0,  1,  1, 0, 2, 0, 0,  0, 1));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 0, 0,  1,  1, 0, 2, 0, 0,  1, 2));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 0, 0,  1,  1, 0, 2, 0, 0,  2, 3));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 1, 0,  0,  0, 1, 3, 1, 0,  3, 3));
        // STEP 2 with STOP in the same cycle as the last commit
        tbl.push_back(mk(1, OP_STEP,  2, 0, 0, 0,  0,  1, 0, 3, 0, 0,  3, 3));
        tbl.push_back(mk(0, OP_CLEAR, 0, 0, 0, 0,  1,  1, 0, 3, 0, 0,  3, 4));
        tbl.push_back(mk(0, OP_CLEAR, 0, 1, 0, 0,  1,  1, 0, 3, 0, 0,  4, 5));
        tbl.push_back(mk(1, OP_STOP,  0, 1, 0, 0,  0,  0, 1, 2, 1, 0,  5, 5));
        tbl.push_back(mk(1, OP_CLEAR, 0, 0, 0, 0,  0,  0, 0, 0, 0, 0,  0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i], 1'b0, $sformatf("vec%0d", i), en_seen);
        end

        // reset in the middle of a run
        v = idle_vec(); v.cv = 1; v.op = OP_RUN;
        run_cycle(v, 1'b1, "rstrun.go", en_seen);
        for (int i = 0; i < 3; i++) begin
            v = idle_vec(); v.cm = 1;
            run_cycle(v, 1'b1, "rstrun.run", en_seen);
        end
        apply_reset("rstrun.reset");

`ifdef DIFF_TIMEOUT_EN
        // watchdog: RUN with no commits halts after TIMEOUT enabled cycles
        v = idle_vec(); v.cv = 1; v.op = OP_RUN;
        run_cycle(v, 1'b1, "wd1.go", en_seen);
        en_count = 0;
        for (int k = 1; k <= 100 && !halted; k++) begin
            v = idle_vec();
            run_cycle(v, 1'b1, "wd1.run", en_seen);
            if (en_seen) en_count++;
        end
        chk("wd1.enabled_cycles", en_count, 16);
        chk("wd1.cause", halt_cause, 4);
        // a commit in enabled cycle 10 restarts the count
        v = idle_vec(); v.cv = 1; v.op = OP_RUN;
        run_cycle(v, 1'b1, "wd2.go", en_seen);
        en_count = 0;
        for (int k = 1; k <= 100 && !halted; k++) begin
            v = idle_vec(); v.cm = (k == 10);
            run_cycle(v, 1'b1, "wd2.run", en_seen);
            if (en_seen) en_count++;
        end
        chk("wd2.enabled_cycles", en_count, 26);
        chk("wd2.cause", halt_cause, 4);
`else
        en_count = 0;
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            v = idle_vec();
            v.cv  = ($urandom_range(0, 7) == 0);
            v.op  = cmd_op_e'($urandom_range(0, 3));
            v.arg = $urandom_range(0, 6);
            v.cm  = ($urandom_range(0, 2) == 0);
            v.tr  = ($urandom_range(0, 24) == 0);
            v.fl  = ($urandom_range(0, 5) == 0);
            run_cycle(v, 1'b1, "rand", en_seen);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
